// File: rtl/uart_rx_16x.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_16x
//  Description : 8N1 asynchronous serial receiver with 16x oversampling,
//                internal tick divider, valid/ack byte handshake, framing
//                error pulse and sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_16x #(
  parameter int CLKS_PER_TICK = 301,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int BW = $clog2(DATA_BITS) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s, rx_prev;
  logic [1:0]           sync_ok;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [3:0]           tcnt;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 start_det, start_ok, bit_sample, stop_sample;
  logic                 good_byte;

  assign tick      = (presc == PW'(CLKS_PER_TICK - 1));
  assign busy      = (state != IDLE);
  assign good_byte = stop_sample & rx_s;

  // Two-flop synchronizer; rx_prev only becomes 1 from a genuinely sampled
  // high, so a line already low when reset is released is never a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      sync_ok <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      sync_ok <= {sync_ok[0], 1'b1};
      rx_prev <= sync_ok[1] ? rx_s : 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_nxt   = state;
    start_det   = 1'b0;
    start_ok    = 1'b0;
    bit_sample  = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          start_det = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (tick && tcnt == 4'd7) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            start_ok  = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (tick && tcnt == 4'd15) begin
          bit_sample = 1'b1;
          if (bitcnt == BW'(DATA_BITS - 1)) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick && tcnt == 4'd15) begin
          stop_sample = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Prescaler, tick counter, bit counter and shift register; the start edge
  // restarts the prescaler and tick counter to phase-align to the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      tcnt   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      if (start_det || tick) presc <= '0;
      else                   presc <= presc + 1'b1;

      if (start_det || start_ok) tcnt <= '0;
      else if (tick)             tcnt <= tcnt + 1'b1;

      if (start_ok)        bitcnt <= '0;
      else if (bit_sample) bitcnt <= bitcnt + 1'b1;

      if (bit_sample) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

  // Output byte, handshake, overrun and framing-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      framing_err <= stop_sample & ~rx_s;
      if (good_byte) begin
        // Newest byte wins; an ack on this clock consumes the old one.
        data_out   <= shreg;
        data_valid <= 1'b1;
        if (data_valid && !data_ack)     overrun <= 1'b1;
        else if (data_valid && data_ack) overrun <= 1'b0;
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
